restador: RTL and testbench
===========================

// Module: restador
// PURPOSE
//   Registered unsigned/two's-complement subtractor: diff = a - b, plus borrow flag.
//   Built as a ripple chain of 1-bit full subtractors with one output register stage.
//   Datapath leaf used wherever the ALU needs a subtraction with borrow-out.
// PARAMETERS
//   WIDTH   4   operand and result width in bits (>= 2)
// PORTS
//   clk        input   1      single clock; all state updates on rising edge
//   rst        input   1      synchronous, active-high reset
//   a          input   WIDTH  minuend (unsigned; two's-complement view for ovf)
//   b          input   WIDTH  subtrahend
//   diff       output  WIDTH  registered (a - b) mod 2^WIDTH
//   carri_out  output  1      registered borrow-out: 1 when a < b (unsigned)
//   ovf        output  1      signed overflow flag; present only with RESTADOR_OVF_EN
//   One clock; reset is synchronous and active-high.
// BEHAVIOUR
//   - Reset: on a rising clk edge with rst=1, diff=0, carri_out=0 (and ovf=0).
//     rst takes priority over the new a/b sample on that edge.
//   - Latency: 1 cycle. On each rising edge with rst=0, the outputs load
//     diff <= a - b and carri_out <= (a < b), sampled from a/b at that edge.
//     Outputs hold between edges; there is no enable and no handshake.
//   - Arithmetic: ripple chain, bit i: d_i = a_i ^ b_i ^ br_i;
//     br_{i+1} = (~a_i & b_i) | (~(a_i ^ b_i) & br_i); br_0 = 0.
//     carri_out = br_WIDTH. diff wraps modulo 2^WIDTH.
//   - Boundaries: a==b gives diff=0, carri_out=0; a=0,b=max gives diff=1,
//     carri_out=1; b=0 gives diff=a, carri_out=0.
//   - Reset asserted mid-stream clears the outputs on that edge. The first
//     valid result appears one edge after rst deasserts.
//   - No X propagation from reset: every output register is reset.
// CONFIGURATION
//   RESTADOR_OVF_EN defined: adds output port ovf (1 bit, registered, same
//     latency). ovf = (a[W-1] != b[W-1]) && (diff_next[W-1] != a[W-1]), i.e.
//     signed result outside [-2^(W-1), 2^(W-1)-1]. Reset value 0.
//   RESTADOR_OVF_EN undefined: the ovf port and its logic do not exist; all
//     other behaviour is identical.
// TESTING
//   1. rst=1 for 2 edges, a=9, b=3 -> diff=0, carri_out=0 (ovf=0) while in reset.
//   2. rst=0, a=9, b=3 -> after next edge diff=6, carri_out=0; unchanged before the edge.
//   3. a=3, b=9 -> diff=10 (4'hA), carri_out=1; a=0, b=15 -> diff=1, carri_out=1.
//   4. a=7, b=7 -> diff=0, carri_out=0; a=15, b=0 -> diff=15, carri_out=0.
//   5. Exhaustive sweep a=0..15 x b=0..15, one pair per cycle -> each result
//      matches (a-b)&4'hF and (a<b) exactly one edge after the operands are applied.
//   6. With RESTADOR_OVF_EN: a=7, b=15 (7-(-1)) -> diff=8, ovf=1; a=8, b=1 ->
//      diff=7, ovf=1; a=5, b=3 -> ovf=0. Also assert rst mid-sweep -> all outputs 0.

Source files
------------

// File: rtl/restador_if.sv
// Operand/result bundle for the restador subtractor.
// The ovf signal exists only when RESTADOR_OVF_EN is defined.
interface restador_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] diff;
   logic             carri_out;
`ifdef RESTADOR_OVF_EN
   logic             ovf;
`endif

`ifdef RESTADOR_OVF_EN
   modport master (
      output a, b,
      input  diff, carri_out, ovf
   );
   modport slave (
      input  a, b,
      output diff, carri_out, ovf
   );
`else
   modport master (
      output a, b,
      input  diff, carri_out
   );
   modport slave (
      input  a, b,
      output diff, carri_out
   );
`endif
endinterface

// File: rtl/restador.sv
// Registered ripple-borrow subtractor: diff = a - b, carri_out = borrow.
// Define RESTADOR_OVF_EN to add the registered signed-overflow flag ovf.
module restador #(
   parameter int WIDTH = 4
) (
   input logic       clk,
   input logic       rst,
   restador_if.slave bus
);

   logic [WIDTH-1:0] d_next;
   logic [WIDTH:0]   br;

   assign br[0] = 1'b0;

   // One full subtractor per bit; borrow ripples toward the MSB.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fs
      logic ai;
      logic bi;
      assign ai        = bus.a[i];
      assign bi        = bus.b[i];
      assign d_next[i] = ai ^ bi ^ br[i];
      assign br[i+1]   = (~ai & bi)
                       | (~(ai ^ bi) & br[i]);
   end

`ifdef RESTADOR_OVF_EN
   logic ovf_next;

   // Operands of opposite sign, result sign differs from minuend.
   assign ovf_next =
      (bus.a[WIDTH-1] != bus.b[WIDTH-1])
      && (d_next[WIDTH-1] != bus.a[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ovf <= 1'b0;
      end else begin
         bus.ovf <= ovf_next;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.diff      <= '0;
         bus.carri_out <= 1'b0;
      end else begin
         bus.diff      <= d_next;
         bus.carri_out <= br[WIDTH];
      end
   end

endmodule

// File: tb/tb_restador.sv
// Directed + exhaustive scoreboard bench for restador (WIDTH=4).
// Build with RESTADOR_OVF_EN to also check the ovf flag.
module tb_restador;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] diff;
      logic         co;
      logic         ov;
   } exp_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   bit   have_prev;
   exp_t prev;
   exp_t sb[$];

   restador_if #(.WIDTH(W)) bus ();

   restador #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(
      input logic         r,
      input logic [W-1:0] x,
      input logic [W-1:0] y
   );
      exp_t         e;
      logic [W-1:0] d;
      int           xi;
      int           yi;
      xi = int'(x);
      yi = int'(y);
      d  = W'((xi - yi) & 15);
      e.diff = r ? '0 : d;
      e.co   = r ? 1'b0 : (xi < yi);
      e.ov   = r ? 1'b0 :
               ((x[W-1] != y[W-1]) && (d[W-1] != x[W-1]));
      return e;
   endfunction

   task automatic check(input string tag, input exp_t e);
      vectors++;
      assert (bus.diff === e.diff) else begin
         miscompares++;
         $error("FAIL %s diff got=%h want=%h", tag, bus.diff, e.diff);
      end
      vectors++;
      assert (bus.carri_out === e.co) else begin
         miscompares++;
         $error("FAIL %s carri_out got=%b want=%b",
                tag, bus.carri_out, e.co);
      end
`ifdef RESTADOR_OVF_EN
      vectors++;
      assert (bus.ovf === e.ov) else begin
         miscompares++;
         $error("FAIL %s ovf got=%b want=%b", tag, bus.ovf, e.ov);
      end
`endif
   endtask

   task automatic step(
      input string        tag,
      input logic         r,
      input logic [W-1:0] x,
      input logic [W-1:0] y
   );
      exp_t e;
      rst   = r;
      bus.a = x;
      bus.b = y;
      #1;
      if (have_prev) check({tag, "_hold"}, prev);
      sb.push_back(model(r, x, y));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL %s scoreboard empty got=0 want=1", tag);
      end else begin
         e = sb.pop_front();
         check(tag, e);
         prev      = e;
         have_prev = 1'b1;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      have_prev   = 1'b0;
      rst   = 1'b1;
      bus.a = '0;
      bus.b = '0;

      step("rst0", 1'b1, 4'd9, 4'd3);
      step("rst1", 1'b1, 4'd9, 4'd3);
      step("9m3",  1'b0, 4'd9, 4'd3);
      step("3m9",  1'b0, 4'd3, 4'd9);
      step("0m15", 1'b0, 4'd0, 4'd15);
      step("7m7",  1'b0, 4'd7, 4'd7);
      step("15m0", 1'b0, 4'd15, 4'd0);
      step("7m15", 1'b0, 4'd7, 4'd15);
      step("8m1",  1'b0, 4'd8, 4'd1);
      step("5m3",  1'b0, 4'd5, 4'd3);

      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            step("sweep", 1'b0, W'(i), W'(j));
            if (i == 8 && j == 5)
               step("midrst", 1'b1, W'(j), W'(i));
         end
      end

      step("post", 1'b0, 4'd2, 4'd11);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
